// File: rtl/fb_pkg.sv
// Shared frame buffer definitions: geometry, capture FSM encoding and write queue entry width.
package fb_pkg;

    localparam int FB_WIDTH   = 640;
    localparam int FB_HEIGHT  = 480;
    localparam int FB_PIXELS  = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W  = 19;
    localparam int FB_DATA_W  = 12;
    localparam int FB_ENTRY_W = FB_ADDR_W + FB_DATA_W;

    typedef enum logic {
        S_WAIT_SOF = 1'b0,
        S_RUN      = 1'b1
    } cap_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// First-word-fall-through write queue with occupancy output. A push into a full
// queue is accepted only when a pop happens in the same cycle.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int WIDTH = FB_ENTRY_W,
    parameter int DEPTH = 512,
    parameter int LVL_W = 10
) (
    input  logic             i_p_clk,
    input  logic             i_rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == LVL_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];
    assign level     = count;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge i_p_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge i_p_clk) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame buffer arbiter: display reads take the port with fixed
// latency, camera writes are address-tagged, queued and drained into idle cycles.
module fb_port_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int FB_PIXELS  = fb_pkg::FB_PIXELS,
    parameter int FIFO_DEPTH = 512,
    parameter int LVL_W      = 10
) (
    input  logic              i_p_clk,
    input  logic              i_rstn,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_sof,
    output logic              o_wr_ready,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_ovf_clr,
    output logic              o_overflow,
    output logic [LVL_W-1:0]  o_fifo_level
);

    import fb_pkg::*;

    localparam int                ENTRY_W   = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

    cap_state_e         state;
    cap_state_e         state_nxt;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  wr_addr_nxt;
    logic               enq;
    logic [ADDR_W-1:0]  enq_addr;

    logic               fifo_pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ENTRY_W-1:0] fifo_head;
    logic [LVL_W-1:0]   fifo_level;
    logic               drop;
    logic [1:0]         rd_pipe;

    // Display reads own the port; a queued write only goes out when no read is requested.
    assign fifo_pop     = !i_rd_req && !fifo_empty;
    assign drop         = enq && fifo_full && !fifo_pop;
    assign o_wr_ready   = !fifo_full;
    assign o_fifo_level = fifo_level;

    fb_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_wr_fifo (
        .i_p_clk   (i_p_clk),
        .i_rstn    (i_rstn),
        .push      (enq),
        .push_data ({enq_addr, i_wr_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    // Capture state and running write address.
    always_ff @(posedge i_p_clk) begin
        if (!i_rstn) begin
            state   <= S_WAIT_SOF;
            wr_addr <= '0;
        end else begin
            state   <= state_nxt;
            wr_addr <= wr_addr_nxt;
        end
    end

    // Tag camera pixels with addresses; sof always restarts the frame at address 0.
    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr;
        enq         = 1'b0;
        enq_addr    = wr_addr;
        case (state)
            S_WAIT_SOF: begin
                if (i_wr_valid && i_wr_sof) begin
                    enq         = 1'b1;
                    enq_addr    = '0;
                    wr_addr_nxt = ADDR_W'(1);
                    state_nxt   = S_RUN;
                end
            end
            S_RUN: begin
                if (i_wr_valid) begin
                    enq = 1'b1;
                    if (i_wr_sof) begin
                        enq_addr    = '0;
                        wr_addr_nxt = ADDR_W'(1);
                    end else begin
                        enq_addr    = wr_addr;
                        wr_addr_nxt = (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
                    end
                end
            end
            default: state_nxt = S_WAIT_SOF;
        endcase
    end

    // Registered BRAM port: read address, queued write, or hold the address when idle.
    always_ff @(posedge i_p_clk) begin
        if (!i_rstn) begin
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
        end else if (i_rd_req) begin
            o_mem_addr <= i_rd_addr;
            o_mem_we   <= 1'b0;
        end else if (!fifo_empty) begin
            o_mem_addr  <= fifo_head[ENTRY_W-1:DATA_W];
            o_mem_wdata <= fifo_head[DATA_W-1:0];
            o_mem_we    <= 1'b1;
        end else begin
            o_mem_we <= 1'b0;
        end
    end

    // Fixed-latency read return: address stage, BRAM stage, then the output register.
    always_ff @(posedge i_p_clk) begin
        if (!i_rstn) begin
            rd_pipe    <= '0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            rd_pipe    <= {rd_pipe[0], i_rd_req};
            o_rd_valid <= rd_pipe[1];
            if (rd_pipe[1]) begin
                o_rd_data <= i_mem_rdata;
            end
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_p_clk) begin
        if (!i_rstn) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            o_overflow <= 1'b0;
        end
    end

endmodule
